// File: rtl/m68k_dma_master_if.sv
// ---------------------------------------------------------------------------
// m68k_dma_master_if
// Purpose : bundles the 68000-style bus signals that the DMA master uses to
//           win the bus from the CPU and to run read/write cycles against the
//           existing responders.
// Signals :
//   BR_L, BGACK_L           bus request / grant acknowledge (master drives)
//   BG_L, BusAS_L           bus grant / muxed system AS_L (bus side drives)
//   CPU_DMA_Select          mux select, 1 = CPU owns bus, 0 = DMA owns bus
//   DMA_Address/DataOut     cycle address and write data
//   DMA_AS_L/UDS_L/LDS_L    strobes, DMA_RW 1 = read / 0 = write
//   DataBusIn, Dtack_L      read data and cycle termination (bus side drives)
// Modports: master = DMA engine, slave = CPU/mux/responder side.
// ---------------------------------------------------------------------------
interface m68k_dma_master_if;
    logic        BR_L;
    logic        BG_L;
    logic        BGACK_L;
    logic        BusAS_L;
    logic        CPU_DMA_Select;
    logic [31:0] DMA_Address;
    logic [15:0] DMA_DataOut;
    logic        DMA_AS_L;
    logic        DMA_UDS_L;
    logic        DMA_LDS_L;
    logic        DMA_RW;
    logic [15:0] DataBusIn;
    logic        Dtack_L;

    modport master (
        output BR_L, BGACK_L, CPU_DMA_Select, DMA_Address, DMA_DataOut,
               DMA_AS_L, DMA_UDS_L, DMA_LDS_L, DMA_RW,
        input  BG_L, BusAS_L, DataBusIn, Dtack_L
    );

    modport slave (
        input  BR_L, BGACK_L, CPU_DMA_Select, DMA_Address, DMA_DataOut,
               DMA_AS_L, DMA_UDS_L, DMA_LDS_L, DMA_RW,
        output BG_L, BusAS_L, DataBusIn, Dtack_L
    );
endinterface

// File: rtl/m68k_dma_master.sv
// ---------------------------------------------------------------------------
// m68k_dma_master
// Purpose : bus-master DMA engine copying a block of 16-bit words from a
//           source to a destination address using 68000-style asynchronous
//           bus cycles terminated by Dtack_L. The bus is obtained with the
//           BR_L/BG_L/BGACK_L handshake and released every BURST_LEN words.
// Ports   :
//   Clock, Reset_H          clock and synchronous active-high reset
//   Start                   one-cycle pulse latching SrcAddr/DstAddr/WordCount
//   SrcAddr, DstAddr        byte addresses (bit 0 ignored)
//   WordCount               number of words to copy
//   Busy, Done, Error       status: busy level, completion pulse, sticky timeout
//   bus                     bus signals (see m68k_dma_master_if)
// All outputs are registered: each state's bus values are loaded on the edge
// that enters the state, so the outputs always match the current state.
// ---------------------------------------------------------------------------
module m68k_dma_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int BURST_LEN      = 16
) (
    input  logic               Clock,
    input  logic               Reset_H,
    input  logic               Start,
    input  logic [31:0]        SrcAddr,
    input  logic [31:0]        DstAddr,
    input  logic [15:0]        WordCount,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    m68k_dma_master_if.master  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_GRANT, S_R_SETUP, S_R_STROBE, S_R_END,
        S_W_SETUP, S_W_STROBE, S_W_END, S_ABORT, S_RELEASE
    } state_t;

    state_t        r_state;
    logic [31:0]   r_src;
    logic [31:0]   r_dst;
    logic [15:0]   r_remain;
    logic [BW-1:0] r_burst;
    logic [TW-1:0] r_tcnt;
    logic [15:0]   r_hold;
    logic          r_done_pend;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_br_l;
    logic          r_bgack_l;
    logic          r_sel;
    logic [31:0]   r_addr;
    logic [15:0]   r_dout;
    logic          r_strb_l;
    logic          r_rw;

    logic [31:0]   w_src_next;
    logic [31:0]   w_dst_next;
    logic [BW-1:0] w_burst_next;
    logic          w_timeout;

    // Next-word addresses wrap naturally at 32 bits; timeout fires on the
    // TIMEOUT_CYCLES-th strobe cycle without Dtack_L.
    assign w_src_next   = r_src + 32'd2;
    assign w_dst_next   = r_dst + 32'd2;
    assign w_burst_next = r_burst + BW'(1);
    assign w_timeout    = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Transfer FSM with registered bus and status outputs.
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            r_state     <= S_IDLE;
            r_src       <= 32'd0;
            r_dst       <= 32'd0;
            r_remain    <= 16'd0;
            r_burst     <= '0;
            r_tcnt      <= '0;
            r_hold      <= 16'd0;
            r_done_pend <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_br_l      <= 1'b1;
            r_bgack_l   <= 1'b1;
            r_sel       <= 1'b1;
            r_addr      <= 32'd0;
            r_dout      <= 16'd0;
            r_strb_l    <= 1'b1;
            r_rw        <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_error <= 1'b0;
                        if (WordCount == 16'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_src       <= SrcAddr & 32'hFFFF_FFFE;
                            r_dst       <= DstAddr & 32'hFFFF_FFFE;
                            r_remain    <= WordCount;
                            r_done_pend <= 1'b0;
                            r_busy      <= 1'b1;
                            r_br_l      <= 1'b0;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // Take the bus only once the CPU has finished its cycle.
                    if (!bus.BG_L && bus.BusAS_L) begin
                        r_br_l    <= 1'b1;
                        r_bgack_l <= 1'b0;
                        r_sel     <= 1'b0;
                        r_burst   <= '0;
                        r_state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_addr  <= {r_src[31:1], 1'b0};
                    r_rw    <= 1'b1;
                    r_state <= S_R_SETUP;
                end
                S_R_SETUP: begin
                    r_strb_l <= 1'b0;
                    r_tcnt   <= '0;
                    r_state  <= S_R_STROBE;
                end
                S_R_STROBE: begin
                    if (!bus.Dtack_L) begin
                        r_hold   <= bus.DataBusIn;
                        r_strb_l <= 1'b1;
                        r_state  <= S_R_END;
                    end else if (w_timeout) begin
                        r_strb_l    <= 1'b1;
                        r_error     <= 1'b1;
                        r_done_pend <= 1'b1;
                        r_state     <= S_ABORT;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_R_END: begin
                    r_addr  <= {r_dst[31:1], 1'b0};
                    r_rw    <= 1'b0;
                    r_dout  <= r_hold;
                    r_state <= S_W_SETUP;
                end
                S_W_SETUP: begin
                    r_strb_l <= 1'b0;
                    r_tcnt   <= '0;
                    r_state  <= S_W_STROBE;
                end
                S_W_STROBE: begin
                    if (!bus.Dtack_L) begin
                        r_strb_l <= 1'b1;
                        r_state  <= S_W_END;
                    end else if (w_timeout) begin
                        r_strb_l    <= 1'b1;
                        r_error     <= 1'b1;
                        r_done_pend <= 1'b1;
                        r_state     <= S_ABORT;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_W_END: begin
                    r_src    <= w_src_next;
                    r_dst    <= w_dst_next;
                    r_remain <= r_remain - 16'd1;
                    r_burst  <= w_burst_next;
                    if (r_remain == 16'd1) begin
                        r_done_pend <= 1'b1;
                        r_bgack_l   <= 1'b1;
                        r_sel       <= 1'b1;
                        r_rw        <= 1'b1;
                        r_state     <= S_RELEASE;
                    end else if (w_burst_next == BW'(BURST_LEN)) begin
                        r_bgack_l <= 1'b1;
                        r_sel     <= 1'b1;
                        r_rw      <= 1'b1;
                        r_state   <= S_RELEASE;
                    end else begin
                        r_addr  <= {w_src_next[31:1], 1'b0};
                        r_rw    <= 1'b1;
                        r_state <= S_R_SETUP;
                    end
                end
                S_ABORT: begin
                    r_bgack_l <= 1'b1;
                    r_sel     <= 1'b1;
                    r_rw      <= 1'b1;
                    r_state   <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (r_done_pend) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_br_l  <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy               = r_busy;
    assign Done               = r_done;
    assign Error              = r_error;
    assign bus.BR_L           = r_br_l;
    assign bus.BGACK_L        = r_bgack_l;
    assign bus.CPU_DMA_Select = r_sel;
    assign bus.DMA_Address    = r_addr;
    assign bus.DMA_DataOut    = r_dout;
    assign bus.DMA_AS_L       = r_strb_l;
    assign bus.DMA_UDS_L      = r_strb_l;
    assign bus.DMA_LDS_L      = r_strb_l;
    assign bus.DMA_RW         = r_rw;
endmodule

// File: tb/tb_m68k_dma_master.sv
// ---------------------------------------------------------------------------
// tb_m68k_dma_master
// Directed bench for m68k_dma_master: a negedge bus model grants the bus,
// acknowledges strobes with zero wait (optionally hanging one read), supplies
// read data as a fixed function of address and logs every bus cycle.
// ---------------------------------------------------------------------------
module tb_m68k_dma_master;
    logic        clk = 1'b0;
    logic        Reset_H;
    logic        Start;
    logic [31:0] SrcAddr;
    logic [31:0] DstAddr;
    logic [15:0] WordCount;
    logic        Busy;
    logic        Done;
    logic        Error;

    m68k_dma_master_if bus();

    m68k_dma_master #(.TIMEOUT_CYCLES(8), .BURST_LEN(16)) dut (
        .Clock     (clk),
        .Reset_H   (Reset_H),
        .Start     (Start),
        .SrcAddr   (SrcAddr),
        .DstAddr   (DstAddr),
        .WordCount (WordCount),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // bus log and event counters
    logic [31:0] rd_addr [0:31];
    logic [31:0] wr_addr [0:31];
    logic [15:0] wr_data [0:31];
    int rd_cnt, wr_cnt, done_cnt, busy_fall, br_fall, rel_cnt, wr_at_first_rel;
    int as_run, max_run;
    int rule_err = 0;
    int hang_en = 0;
    int hang_idx = 0;
    logic prev_busy = 1'b0, prev_br = 1'b1, prev_bgack = 1'b1, prev_as = 1'b1, prev_rw = 1'b1;
    logic [31:0] prev_addr = 32'd0;

    // source memory contents are a fixed function of the address
    function automatic logic [15:0] mem_f(input logic [31:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h3C5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // CPU arbiter, responder and bus-rule monitor
    always @(negedge clk) begin
        if (Done === 1'b1) done_cnt++;
        if (prev_busy && !Busy) busy_fall++;
        prev_busy = Busy;
        if (prev_br && !bus.BR_L) br_fall++;
        prev_br = bus.BR_L;
        if (!prev_bgack && bus.BGACK_L) begin
            if (rel_cnt == 0) wr_at_first_rel = wr_cnt;
            rel_cnt++;
        end
        prev_bgack = bus.BGACK_L;
        if (bus.DMA_UDS_L !== bus.DMA_AS_L || bus.DMA_LDS_L !== bus.DMA_AS_L) rule_err++;
        if (bus.CPU_DMA_Select !== bus.BGACK_L) rule_err++;
        if (bus.DMA_Address[0] !== 1'b0) rule_err++;
        if (!prev_as && !bus.DMA_AS_L && (bus.DMA_Address !== prev_addr || bus.DMA_RW !== prev_rw)) rule_err++;
        prev_as = bus.DMA_AS_L; prev_addr = bus.DMA_Address; prev_rw = bus.DMA_RW;
        if (!bus.DMA_AS_L) begin
            as_run++;
            if (as_run > max_run) max_run = as_run;
            if (hang_en != 0 && bus.DMA_RW && rd_cnt == hang_idx) begin
                bus.Dtack_L = 1'b1;
            end else if (bus.Dtack_L) begin
                bus.Dtack_L = 1'b0;
                if (bus.DMA_RW) begin
                    bus.DataBusIn = mem_f(bus.DMA_Address);
                    if (rd_cnt < 32) rd_addr[rd_cnt] = bus.DMA_Address;
                    rd_cnt++;
                end else begin
                    if (wr_cnt < 32) begin
                        wr_addr[wr_cnt] = bus.DMA_Address;
                        wr_data[wr_cnt] = bus.DMA_DataOut;
                    end
                    wr_cnt++;
                end
            end
        end else begin
            as_run = 0;
            bus.Dtack_L = 1'b1;
        end
        bus.BG_L = bus.BR_L;
    end

    task automatic clear_counts();
        @(posedge clk); #1;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_fall = 0; br_fall = 0;
        rel_cnt = 0; wr_at_first_rel = -1; as_run = 0; max_run = 0;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        Start = 1'b1; SrcAddr = s; DstAddr = d; WordCount = n;
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (Done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, Done}, 32'd1);
    endtask

    task automatic check_copy(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_rd_addr"}, rd_addr[i], s + 32'(2 * i));
            check({tag, "_wr_addr"}, wr_addr[i], d + 32'(2 * i));
            check({tag, "_wr_data"}, {16'd0, wr_data[i]}, {16'd0, mem_f(s + 32'(2 * i))});
        end
    endtask

    initial begin
        Reset_H = 1'b1; Start = 1'b0; SrcAddr = 32'd0; DstAddr = 32'd0; WordCount = 16'd0;
        bus.BG_L = 1'b1; bus.BusAS_L = 1'b1; bus.Dtack_L = 1'b1; bus.DataBusIn = 16'd0;
        repeat (3) @(negedge clk);
        // reset values
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_error", {31'd0, Error}, 32'd0);
        check("rst_br", {31'd0, bus.BR_L}, 32'd1);
        check("rst_bgack", {31'd0, bus.BGACK_L}, 32'd1);
        check("rst_sel", {31'd0, bus.CPU_DMA_Select}, 32'd1);
        check("rst_as", {29'd0, bus.DMA_AS_L, bus.DMA_UDS_L, bus.DMA_LDS_L}, 32'd7);
        check("rst_rw", {31'd0, bus.DMA_RW}, 32'd1);
        check("rst_addr", bus.DMA_Address, 32'd0);
        check("rst_dout", {16'd0, bus.DMA_DataOut}, 32'd0);
        Reset_H = 1'b0;

        // 4-word copy
        clear_counts();
        do_start(32'h00F0_0000, 32'h00F0_1000, 16'd4);
        check("t1_busy_on", {31'd0, Busy}, 32'd1);
        wait_done("t1_done", 200);
        check("t1_busy_at_done", {31'd0, Busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_wr_cnt", wr_cnt, 32'd4);
        check("t1_error", {31'd0, Error}, 32'd0);
        check_copy("t1", 32'h00F0_0000, 32'h00F0_1000, 4);

        // 20 words across two bus tenures
        clear_counts();
        do_start(32'h0001_0000, 32'h0002_0000, 16'd20);
        wait_done("t2_done", 400);
        repeat (5) @(negedge clk);
        check("t2_wr_cnt", wr_cnt, 32'd20);
        check("t2_rel_cnt", rel_cnt, 32'd2);
        check("t2_wr_first_rel", wr_at_first_rel, 32'd16);
        check("t2_br_fall", br_fall, 32'd2);
        check("t2_busy_fall", busy_fall, 32'd1);
        check("t2_done_cnt", done_cnt, 32'd1);
        check("t2_wr15", wr_addr[15], 32'h0002_001E);
        check("t2_wr19_data", {16'd0, wr_data[19]}, {16'd0, mem_f(32'h0001_0026)});

        // timeout on the third read
        clear_counts();
        hang_en = 1; hang_idx = 2;
        do_start(32'h0000_2000, 32'h0000_3000, 16'd6);
        wait_done("t3_done", 200);
        hang_en = 0;
        repeat (5) @(negedge clk);
        check("t3_error", {31'd0, Error}, 32'd1);
        check("t3_wr_cnt", wr_cnt, 32'd2);
        check("t3_max_strobe", max_run, 32'd8);
        check("t3_done_cnt", done_cnt, 32'd1);
        check("t3_busy", {31'd0, Busy}, 32'd0);
        check("t3_bgack", {31'd0, bus.BGACK_L}, 32'd1);
        check("t3_sel", {31'd0, bus.CPU_DMA_Select}, 32'd1);

        // zero-length request
        clear_counts();
        do_start(32'h0000_4000, 32'h0000_5000, 16'd0);
        check("t4_done_next", {31'd0, Done}, 32'd1);
        check("t4_busy", {31'd0, Busy}, 32'd0);
        check("t4_err_clr", {31'd0, Error}, 32'd0);
        @(negedge clk);
        check("t4_done_pulse", {31'd0, Done}, 32'd0);
        repeat (4) @(negedge clk);
        check("t4_br_fall", br_fall, 32'd0);
        check("t4_strobes", max_run, 32'd0);

        // Start while busy is ignored
        clear_counts();
        do_start(32'h0000_4000, 32'h0000_5000, 16'd4);
        repeat (3) @(negedge clk);
        do_start(32'h0000_9000, 32'h0000_A000, 16'd9);
        wait_done("t4b_done", 200);
        repeat (5) @(negedge clk);
        check("t4b_wr_cnt", wr_cnt, 32'd4);
        check("t4b_done_cnt", done_cnt, 32'd1);
        check_copy("t4b", 32'h0000_4000, 32'h0000_5000, 4);

        // address wrap and odd destination
        clear_counts();
        do_start(32'hFFFF_FFFE, 32'h0000_1001, 16'd2);
        wait_done("t5_done", 200);
        repeat (3) @(negedge clk);
        check("t5_rd0", rd_addr[0], 32'hFFFF_FFFE);
        check("t5_rd1", rd_addr[1], 32'h0000_0000);
        check("t5_wr0", wr_addr[0], 32'h0000_1000);
        check("t5_wr1", wr_addr[1], 32'h0000_1002);
        check("t5_wr1_data", {16'd0, wr_data[1]}, {16'd0, mem_f(32'h0000_0000)});

        // reset during a write strobe
        clear_counts();
        do_start(32'h0000_6000, 32'h0000_7000, 16'd4);
        begin
            int k;
            k = 0;
            while (!(bus.DMA_AS_L === 1'b0 && bus.DMA_RW === 1'b0) && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("t6_wstrobe_seen", {31'd0, (k < 100)}, 32'd1);
        end
        Reset_H = 1'b1;
        @(negedge clk);
        check("t6_as", {29'd0, bus.DMA_AS_L, bus.DMA_UDS_L, bus.DMA_LDS_L}, 32'd7);
        check("t6_bgack", {31'd0, bus.BGACK_L}, 32'd1);
        check("t6_sel", {31'd0, bus.CPU_DMA_Select}, 32'd1);
        check("t6_busy", {31'd0, Busy}, 32'd0);
        check("t6_br", {31'd0, bus.BR_L}, 32'd1);
        Reset_H = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt, 32'd0);

        clear_counts();
        do_start(32'h0000_6000, 32'h0000_7000, 16'd3);
        wait_done("t6b_done", 200);
        repeat (3) @(negedge clk);
        check("t6b_wr_cnt", wr_cnt, 32'd3);
        check_copy("t6b", 32'h0000_6000, 32'h0000_7000, 3);

        check("bus_rules", rule_err, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
